// File: rtl/prll_bs_pkg.sv
// prll_bs_pkg: shared state encoding and word-field helpers for the parallel bus controller
package prll_bs_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, SEND} bs_state_t;
  localparam int ID_W = 8;
  localparam int MAX_BITS = 64;
  function automatic logic [ID_W-1:0] dest_id(input logic [MAX_BITS-1:0] word, input int bits);
    return ID_W'(word >> (bits - ID_W));
  endfunction
endpackage

// File: rtl/prll_bs_rr_pick.sv
// prll_bs_rr_pick: combinational round-robin pick of the next requester after the last winner
module prll_bs_rr_pick #(
  parameter int drvrs = 4
) (
  input  logic [drvrs-1:0]         req,
  input  logic [$clog2(drvrs)-1:0] last,
  output logic                     any,
  output logic [$clog2(drvrs)-1:0] nxt
);
  localparam int GW = $clog2(drvrs);
  // Scan farthest offset first so the nearest requester after last wins
  always_comb begin
    any = |req;
    nxt = last;
    for (int k = drvrs; k >= 1; k--)
      if (req[GW'((int'(last) + k) % drvrs)]) nxt = GW'((int'(last) + k) % drvrs);
  end
endmodule

// File: rtl/prll_bs_rr_ctrl.sv
// prll_bs_rr_ctrl: round-robin bus controller moving one word per transfer from a driver FIFO to its destination(s)
module prll_bs_rr_ctrl
  import prll_bs_pkg::*;
#(
  parameter int              bits      = 32,
  parameter int              drvrs     = 4,
  parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arb_en,
  input  logic [drvrs-1:0]         pndng,
  input  logic [drvrs*bits-1:0]    D_pop,
  output logic [drvrs-1:0]         pop,
  output logic [drvrs-1:0]         push,
  output logic [bits-1:0]          D_push,
  output logic                     busy,
  output logic [$clog2(drvrs)-1:0] grant_id,
  output logic [15:0]              drop_cnt
);
  localparam int GW = $clog2(drvrs);
  bs_state_t        state, state_n;
  logic             any, bad;
  logic [GW-1:0]    nxt;
  logic [bits-1:0]  head;
  logic [ID_W-1:0]  id;
  logic [drvrs-1:0] own, mask, mask_d;
  prll_bs_rr_pick #(.drvrs(drvrs)) u_pick (
    .req (pndng),
    .last(grant_id),
    .any (any),
    .nxt (nxt)
  );
  always_comb begin
    head    = D_pop[grant_id*bits +: bits];
    id      = dest_id(MAX_BITS'(head), bits);
    own     = drvrs'(1) << grant_id;
    bad     = id >= ID_W'(drvrs) && id != broadcast;
    mask_d  = id < ID_W'(drvrs) ? drvrs'(1) << id : id == broadcast ? ~own : '0;
    state_n = state == IDLE ? (arb_en && any ? GRANT : IDLE) : state == GRANT ? SEND : IDLE;
  end
  // Outputs decode registered state only; pndng never reaches pop combinationally
  assign pop  = state == GRANT ? own : '0;
  assign push = state == SEND ? mask : '0;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant_id <= GW'(drvrs - 1);
      D_push   <= '0;
      mask     <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n == GRANT) grant_id <= nxt;
      if (state == GRANT) begin
        D_push <= head;
        mask   <= mask_d;
        if (bad && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_prll_bs_rr_ctrl.sv
// tb_prll_bs_rr_ctrl: scenario tasks plus randomized traffic checked against a queue-based reference model
module tb_prll_bs_rr_ctrl;
  localparam int BITS = 32;
  localparam int N = 4;
  logic            clk = 0, reset = 1, arb_en = 1;
  logic [N-1:0]    pndng, pop, push;
  logic [N*BITS-1:0] D_pop;
  logic [BITS-1:0] D_push;
  logic            busy;
  logic [1:0]      grant_id;
  logic [15:0]     drop_cnt;
  int errors = 0, checks = 0;
  logic [31:0] mem [N][16];
  int hd [N];
  int tl [N];
  int m_last, m_drops;

  prll_bs_rr_ctrl #(.bits(BITS), .drvrs(N), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .arb_en(arb_en), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .push(push), .D_push(D_push), .busy(busy), .grant_id(grant_id), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fifos();
    for (int i = 0; i < N; i++) begin
      pndng[i] = hd[i] != tl[i];
      D_pop[i*BITS +: BITS] = pndng[i] ? mem[i][hd[i]] : 32'h0;
    end
  endtask

  task automatic push_word(input int d, input logic [31:0] w);
    mem[d][tl[d]] = w;
    tl[d]++;
    drive_fifos();
  endtask

  function automatic int pending_total();
    int t = 0;
    for (int i = 0; i < N; i++) t += tl[i] - hd[i];
    return t;
  endfunction

  function automatic int rr_next();
    for (int k = 1; k <= N; k++)
      if (hd[(m_last + k) % N] != tl[(m_last + k) % N]) return (m_last + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_mask(input int src, input logic [31:0] w);
    int d = int'(w[31:24]);
    if (d < N) return N'(1) << d;
    if (d == 255) return ~(N'(1) << src);
    return '0;
  endfunction

  task automatic apply_reset();
    reset = 1;
    arb_en = 1;
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    drive_fifos();
    step();
    step();
    reset = 0;
    m_last = N - 1;
    m_drops = 0;
  endtask

  task automatic do_xfer(input string tag);
    int src;
    logic [31:0] w;
    logic [N-1:0] em, ep;
    src = rr_next();
    if (src < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no pending word in model", tag);
      return;
    end
    w = mem[src][hd[src]];
    em = exp_mask(src, w);
    ep = N'(1) << src;
    step();
    checks++;
    if (pop !== ep || grant_id !== 2'(src) || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s grant: pop=%b grant_id=%0d busy=%b, expected pop=%b grant_id=%0d busy=1", tag, pop, grant_id, busy, ep, src);
    end
    step();
    hd[src]++;
    drive_fifos();
    m_last = src;
    if (w[31:24] >= 8'(N) && w[31:24] != 8'hFF) m_drops++;
    checks++;
    if (push !== em || D_push !== w || pop !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s send: push=%b D_push=%h pop=%b busy=%b, expected push=%b D_push=%h pop=0 busy=1", tag, push, D_push, pop, busy, em, w);
    end
    checks++;
    if (drop_cnt !== 16'(m_drops)) begin
      errors++;
      $display("FAIL %s drop_cnt: got %0d expected %0d", tag, drop_cnt, m_drops);
    end
    step();
    checks++;
    if (pop !== '0 || push !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: pop=%b push=%b busy=%b, expected all zero", tag, pop, push, busy);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    reset = 1;
    step();
    checks++;
    if (pop !== '0 || push !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset strobes: pop=%b push=%b busy=%b expected 0", pop, push, busy);
    end
    checks++;
    if (D_push !== '0 || grant_id !== 2'd3 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset regs: D_push=%h grant_id=%0d drop_cnt=%0d expected 0/3/0", D_push, grant_id, drop_cnt);
    end
    reset = 0;
  endtask

  task automatic test_single();
    apply_reset();
    push_word(1, 32'h0200ABCD);
    #1;
    checks++;
    if (pop !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single comb path: pop=%b busy=%b expected 0", pop, busy);
    end
    do_xfer("single");
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) push_word(i, 32'h00000000 | (k << 8) | i);
    for (int i = 0; i < 2 * N; i++) begin
      do_xfer("round_robin");
      checks++;
      if (grant_id !== 2'(i % N)) begin
        errors++;
        $display("FAIL round_robin order: grant_id=%0d expected %0d", grant_id, i % N);
      end
    end
  endtask

  task automatic test_broadcast();
    apply_reset();
    push_word(2, 32'hFF000001);
    do_xfer("broadcast_d2");
    push_word(0, 32'hFF000002);
    do_xfer("broadcast_d0");
  endtask

  task automatic test_bad_dest();
    apply_reset();
    checks++;
    if (drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL bad_dest start: drop_cnt=%0d expected 0", drop_cnt);
    end
    push_word(0, 32'h07000000);
    do_xfer("bad_dest_07");
    push_word(3, 32'h80000001);
    do_xfer("bad_dest_80");
  endtask

  task automatic test_arb_en();
    apply_reset();
    push_word(1, 32'h00000011);
    push_word(2, 32'h03000022);
    step();
    checks++;
    if (pop !== 4'b0010) begin
      errors++;
      $display("FAIL arb_en grant: pop=%b expected 0010", pop);
    end
    arb_en = 0;
    step();
    hd[1]++;
    drive_fifos();
    checks++;
    if (push !== 4'b0001 || D_push !== 32'h00000011) begin
      errors++;
      $display("FAIL arb_en send: push=%b D_push=%h expected 0001 00000011", push, D_push);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (pop !== '0 || busy !== 1'b0 || grant_id !== 2'd1) begin
        errors++;
        $display("FAIL arb_en hold: pop=%b busy=%b grant_id=%0d expected 0/0/1", pop, busy, grant_id);
      end
    end
    arb_en = 1;
    m_last = 1;
    do_xfer("arb_en_resume");
  endtask

  task automatic test_reset_mid_send();
    apply_reset();
    push_word(1, 32'h00000033);
    step();
    step();
    hd[1]++;
    drive_fifos();
    checks++;
    if (push !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid pre: push=%b expected 0001", push);
    end
    #1 reset = 1;
    #1;
    checks++;
    if (push !== '0 || busy !== 1'b0 || grant_id !== 2'd3 || pop !== '0 || D_push !== '0) begin
      errors++;
      $display("FAIL reset_mid async: push=%b busy=%b grant_id=%0d pop=%b D_push=%h expected 0/0/3/0/0", push, busy, grant_id, pop, D_push);
    end
    #1 reset = 0;
    m_last = N - 1;
    m_drops = 0;
    push_word(1, 32'h01000001);
    push_word(2, 32'h02000002);
    push_word(0, 32'h03000003);
    do_xfer("reset_mid_first");
    checks++;
    if (grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid first grant: grant_id=%0d expected 0", grant_id);
    end
  endtask

  function automatic logic [31:0] rand_word();
    int r = $urandom_range(0, 5);
    logic [7:0] d = r < 4 ? 8'(r) : r == 4 ? 8'hFF : 8'($urandom_range(4, 254));
    return {d, 24'($urandom)};
  endfunction

  task automatic test_random();
    int n;
    apply_reset();
    for (int i = 0; i < N; i++) begin
      n = $urandom_range(0, 5);
      for (int k = 0; k < n; k++) push_word(i, rand_word());
    end
    for (int it = 0; it < 200 && pending_total() > 0; it++) begin
      do_xfer("random");
      if ($urandom_range(0, 9) < 3) begin
        n = $urandom_range(0, N - 1);
        if (tl[n] < 16) push_word(n, rand_word());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_broadcast();
    test_bad_dest();
    test_arb_en();
    test_reset_mid_send();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
